dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single byte-addressable data memory (MEM_BYTES, write_command 00 byte / 01 half / 10 word) between two requesters.
- Requester 0 is the core load/store path; requester 1 is the debug/program-loader port.
- Accepts one request at a time via valid/ready, bounds- and command-checks it, drives the memory for one access cycle, and returns a registered response to the originating requester.
- Round-robin on contention: neither requester can starve the other.

Parameters:
MEM_BYTES, 64, data memory size in bytes; legal range is 0..MEM_BYTES-1
ADDR_W, 32, request/memory address width

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
r0_valid  in  1  requester 0 request valid
r0_ready  out  1  requester 0 request accepted this cycle
r0_we  in  1  1 = store, 0 = load
r0_cmd  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
r0_addr  in  ADDR_W  byte address
r0_wdata  in  32  store data, LSB-aligned
r0_rsp_valid  out  1  one-cycle response strobe
r0_rsp_rdata  out  32  load data, zero-extended to 32 bits
r0_rsp_err  out  1  request rejected (illegal cmd or out of range)
r1_* (same nine signals as r0_*)  -  -  requester 1
mem_write_address  out  ADDR_W  to data memory
mem_write_en  out  1  to data memory
mem_write_data  out  32  to data memory
mem_write_command  out  2  to data memory
mem_read_address  out  ADDR_W  to data memory
mem_read_data  in  32  combinational read data from data memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset value: IDLE.
- Reset values: all ready, rsp_valid and rsp_err outputs 0; rsp_rdata 0; mem_write_en 0; mem addresses, data and command 0; round-robin pointer = requester 0 preferred.
- IDLE
  - rN_ready is asserted combinationally only for the arbitration winner among valid requesters; 0 in every other state.
  - One valid requester: it wins.
  - Both valid: the requester not granted last wins. The pointer updates on every grant.
  - On the accept edge, capture we, cmd, addr, wdata and the requester id; go to ACCESS.
- ACCESS (cycle T+1 after accept at T)
  - Compute err = (cmd == 11) OR (addr + size > MEM_BYTES), with size 1/2/4.
  - The addr + size sum is done in ADDR_W+1 bits, so wrap-around near 0xFFFFFFFF counts as out of range.
  - mem_write_address and mem_read_address = addr; mem_write_command = cmd; mem_write_data = wdata.
  - mem_write_en = we AND NOT err, high for exactly this one cycle.
  - Load data is registered at the end of ACCESS: byte takes [7:0], half takes [15:0], word takes all 32 bits. Upper bits are zeroed; sign extension belongs to the core.
  - For a store or an error, rdata = 0. Go to RESP.
- RESP (T+2)
  - Owner's rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_err valid in the same cycle.
  - The other requester's response outputs stay 0. Go to IDLE.
- Throughput: one request per 3 cycles. Minimum gap between accepts: accept at T, next accept no earlier than T+3.
- A requester holding valid while not granted keeps its request fields stable; the arbiter never drops it.
- Mid-operation reset (resetn low in ACCESS or RESP):
  - return to IDLE next edge;
  - in-flight request discarded; no rsp_valid, no write;
  - pointer reset.
- Error requests never modify memory.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum for cmd (CMD_BYTE=2'b00, CMD_HALF=2'b01, CMD_WORD=2'b10, CMD_ILL=2'b11);
  - typedef enum for FSM state;
  - function cmd_size(cmd) returning 1/2/4 (0 for illegal);
  - a struct for the captured request {we, cmd, addr, wdata, id}.
- One sub-module, rr_arb2: 2-way round-robin grant with a pointer register and an update-on-grant input. Shared later with other 2-port resources.

Test Plan:
- Word read: r0 load, cmd 10, addr 0, memory bytes 0..3 = AA 81 0F F0 -> r0_ready at T, r0_rsp_valid at T+2 with rdata 0xF00F81AA, err 0; r1 outputs stay 0.
- Half store then byte load:
  - r1 store, cmd 01, addr 4, wdata 0x1234BEEF -> mem_write_en high only at T+1, command 01.
  - Then r1 byte load at addr 5 -> rdata 0x000000BE.
- Contention: r0 and r1 valid continuously -> grants alternate r0, r1, r0, r1 at T, T+3, T+6, T+9; each rsp_valid goes only to its owner.
- Errors: word load at addr 61 -> err 1, rdata 0. cmd 11 store at addr 0 -> err 1, no mem_write_en; a later read of addr 0 is unchanged.
- Wrap boundary: word store at addr 0xFFFFFFFE -> err 1 and no write. Byte store at addr 63 -> err 0, write occurs.
- Reset in ACCESS: resetn low during the store's ACCESS cycle -> no rsp_valid, FSM in IDLE; afterwards r0 wins the first contended grant.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the two-requester data-memory arbiter: access commands, FSM state, captured request.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;

    typedef enum logic [1:0] {
        CMD_BYTE = 2'b00,
        CMD_HALF = 2'b01,
        CMD_WORD = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    typedef struct packed {
        logic                   we;
        cmd_e                   cmd;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic                   id;
    } req_t;

    // Bytes touched by an access; 0 marks the illegal encoding.
    function automatic logic [2:0] cmd_size(input cmd_e cmd);
        case (cmd)
            CMD_BYTE: cmd_size = 3'd1;
            CMD_HALF: cmd_size = 3'd2;
            CMD_WORD: cmd_size = 3'd4;
            default:  cmd_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant; combinational grant, pointer register moves on each accepted grant.
// Zero latency; grants nothing while en_i is low, a losing requester keeps priority for the next round.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    // ptr_q names the requester that wins when both are asking.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o[ptr_q] = 1'b1;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i && (gnt_o != 2'b00)) begin
            ptr_d = ~gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressable data memory between core (r0) and debug/loader (r1) ports.
// Accept at T, memory access at T+1, one-cycle response strobe at T+2; requesters wait on ready while busy.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned ADDR_W    = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [1:0]        r0_cmd,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    output logic              r0_rsp_valid,
    output logic [31:0]       r0_rsp_rdata,
    output logic              r0_rsp_err,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [1:0]        r1_cmd,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    output logic              r1_rsp_valid,
    output logic [31:0]       r1_rsp_rdata,
    output logic              r1_rsp_err,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    output logic [1:0]        mem_write_command,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [31:0]       mem_read_data
);

    state_e            state_q;
    req_t              req_q;
    req_t              req_d;
    logic              err_q;
    logic              err_d;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   end_d;
    logic [1:0]        gnt;
    logic              accept;
    logic [31:0]       load_data;
    logic              r0_rsp_valid_q, r1_rsp_valid_q;
    logic              r0_rsp_err_q, r1_rsp_err_q;
    logic [31:0]       r0_rsp_rdata_q, r1_rsp_rdata_q;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .resetn (resetn),
        .req_i  ({r1_valid, r0_valid}),
        .en_i   (state_q == ST_IDLE),
        .upd_i  (accept),
        .gnt_o  (gnt)
    );

    assign accept   = gnt[0] | gnt[1];
    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];

    always_comb begin
        addr_d      = gnt[1] ? r1_addr : r0_addr;
        req_d.we    = gnt[1] ? r1_we : r0_we;
        req_d.cmd   = cmd_e'(gnt[1] ? r1_cmd : r0_cmd);
        req_d.addr  = DMEM_ADDR_W'(addr_d);
        req_d.wdata = gnt[1] ? r1_wdata : r0_wdata;
        req_d.id    = gnt[1];
        // One extra bit so an access wrapping past the top of the address space is out of range.
        end_d = {1'b0, addr_d} + (ADDR_W+1)'(cmd_size(req_d.cmd));
        err_d = (req_d.cmd == CMD_ILL) || (end_d > (ADDR_W+1)'(MEM_BYTES));
    end

    always_comb begin
        load_data = 32'd0;
        if (!req_q.we && !err_q) begin
            case (req_q.cmd)
                CMD_BYTE: load_data = {24'd0, mem_read_data[7:0]};
                CMD_HALF: load_data = {16'd0, mem_read_data[15:0]};
                default:  load_data = mem_read_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            req_q          <= '0;
            err_q          <= 1'b0;
            wen_q          <= 1'b0;
            r0_rsp_valid_q <= 1'b0;
            r0_rsp_err_q   <= 1'b0;
            r0_rsp_rdata_q <= 32'd0;
            r1_rsp_valid_q <= 1'b0;
            r1_rsp_err_q   <= 1'b0;
            r1_rsp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        req_q   <= req_d;
                        err_q   <= err_d;
                        wen_q   <= req_d.we & ~err_d;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    wen_q <= 1'b0;
                    if (req_q.id) begin
                        r1_rsp_valid_q <= 1'b1;
                        r1_rsp_err_q   <= err_q;
                        r1_rsp_rdata_q <= load_data;
                    end else begin
                        r0_rsp_valid_q <= 1'b1;
                        r0_rsp_err_q   <= err_q;
                        r0_rsp_rdata_q <= load_data;
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    r0_rsp_valid_q <= 1'b0;
                    r0_rsp_err_q   <= 1'b0;
                    r0_rsp_rdata_q <= 32'd0;
                    r1_rsp_valid_q <= 1'b0;
                    r1_rsp_err_q   <= 1'b0;
                    r1_rsp_rdata_q <= 32'd0;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Gated by resetn so a reset landing in ACCESS cancels the write on that same edge.
    assign mem_write_en      = wen_q & resetn;
    assign mem_write_address = ADDR_W'(req_q.addr);
    assign mem_read_address  = ADDR_W'(req_q.addr);
    assign mem_write_data    = req_q.wdata;
    assign mem_write_command = req_q.cmd;

    assign r0_rsp_valid = r0_rsp_valid_q;
    assign r0_rsp_err   = r0_rsp_err_q;
    assign r0_rsp_rdata = r0_rsp_rdata_q;
    assign r1_rsp_valid = r1_rsp_valid_q;
    assign r1_rsp_err   = r1_rsp_err_q;
    assign r1_rsp_rdata = r1_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: scoreboard of expected responses/writes, checked by a negedge monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic        r0_we = 1'b0, r1_we = 1'b0;
    logic [1:0]  r0_cmd = 2'b00, r1_cmd = 2'b00;
    logic [31:0] r0_addr = 32'd0, r1_addr = 32'd0;
    logic [31:0] r0_wdata = 32'd0, r1_wdata = 32'd0;
    logic        r0_rsp_valid, r1_rsp_valid;
    logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
    logic        r0_rsp_err, r1_rsp_err;
    logic [31:0] mem_write_address, mem_read_address, mem_write_data;
    logic        mem_write_en;
    logic [1:0]  mem_write_command;
    logic [31:0] mem_read_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = -100;
    logic load_mem = 1'b1;
    logic [7:0] mem [0:63];

    typedef struct { int id; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] cmd; } wr_t;
    typedef struct { int cyc; int id; } acc_t;
    rsp_t exp_q[$];
    wr_t  wr_q[$];
    acc_t acc_q[$];

    dmem_arbiter #(.MEM_BYTES(64), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_cmd(r0_cmd),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_cmd(r1_cmd),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
        .mem_write_address(mem_write_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_write_command(mem_write_command),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: combinational read, write on the clock edge.
    always_comb begin
        mem_read_data = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if ({1'b0, mem_read_address} + 33'(k) < 33'd64)
                mem_read_data[k*8 +: 8] = mem[6'(mem_read_address + 32'(k))];
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[0] <= 8'hAA; mem[1] <= 8'h81; mem[2] <= 8'h0F; mem[3] <= 8'hF0;
        end else if (mem_write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (k < (mem_write_command == 2'b00 ? 1 : mem_write_command == 2'b01 ? 2 : 4) &&
                    {1'b0, mem_write_address} + 33'(k) < 33'd64)
                    mem[6'(mem_write_address + 32'(k))] <= mem_write_data[k*8 +: 8];
            end
        end
    end

    // Monitor: logs accepts, pops and compares writes and responses.
    always @(negedge clk) begin
        if (r0_ready || r1_ready) begin
            chk("ready_onehot", {63'd0, r0_ready & r1_ready}, 64'd0);
            acc_q.push_back('{cyc, r1_ready ? 1 : 0});
            last_acc = cyc;
        end
        if (mem_write_en) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write_addr", {32'd0, mem_write_address}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("write_addr", {32'd0, mem_write_address}, {32'd0, w.addr});
                chk("write_data", {32'd0, mem_write_data}, {32'd0, w.data});
                chk("write_cmd", {62'd0, mem_write_command}, {62'd0, w.cmd});
                chk("write_cycle", 64'(cyc), 64'(last_acc + 1));
            end
        end
        if (r0_rsp_valid || r1_rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {62'd0, r1_rsp_valid, r0_rsp_valid}, 64'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_owner", {62'd0, r1_rsp_valid, r0_rsp_valid}, e.id == 1 ? 64'd2 : 64'd1);
                chk("rsp_rdata", {32'd0, e.id == 1 ? r1_rsp_rdata : r0_rsp_rdata}, {32'd0, e.rdata});
                chk("rsp_err", {63'd0, e.id == 1 ? r1_rsp_err : r0_rsp_err}, {63'd0, e.err});
                chk("other_rsp_zero", e.id == 1 ? {31'd0, r0_rsp_err, r0_rsp_rdata} : {31'd0, r1_rsp_err, r1_rsp_rdata}, 64'd0);
                chk("rsp_cycle", 64'(cyc), 64'(last_acc + 2));
            end
        end else if (r0_rsp_err || r1_rsp_err || r0_rsp_rdata != 0 || r1_rsp_rdata != 0) begin
            chk("idle_rsp_zero", {r0_rsp_err, r1_rsp_err, r0_rsp_rdata | r1_rsp_rdata}, 64'd0);
        end
    end

    task automatic send(input int id, input logic we, input logic [1:0] cmd,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bit got = 0;
        if (id == 0) begin r0_valid = 1; r0_we = we; r0_cmd = cmd; r0_addr = addr; r0_wdata = wdata; end
        else         begin r1_valid = 1; r1_we = we; r1_cmd = cmd; r1_addr = addr; r1_wdata = wdata; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((id == 0 && r0_ready) || (id == 1 && r1_ready)) got = 1;
        end
        if (!got) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (id == 0) r0_valid = 0; else r1_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            chk("drain_timeout", 64'(exp_q.size() + wr_q.size()), 64'd0);
            exp_q.delete();
            wr_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {62'd0, r1_ready, r0_ready}, 64'd0);
        chk("rst_rsp", {r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err, r0_rsp_rdata | r1_rsp_rdata}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_write_en}, 64'd0);
        chk("rst_mem_bus", {mem_write_address | mem_read_address, mem_write_data}, 64'd0);
        chk("rst_mem_cmd", {62'd0, mem_write_command}, 64'd0);
        @(posedge clk); #1;
        resetn = 1; load_mem = 0;

        // Word read from r0.
        exp_q.push_back('{0, 32'hF00F81AA, 1'b0});
        send(0, 0, 2'b10, 32'd0, 32'd0);
        drain();

        // Half store then byte load from r1.
        wr_q.push_back('{32'd4, 32'h1234BEEF, 2'b01});
        exp_q.push_back('{1, 32'd0, 1'b0});
        send(1, 1, 2'b01, 32'd4, 32'h1234BEEF);
        drain();
        exp_q.push_back('{1, 32'h000000BE, 1'b0});
        send(1, 0, 2'b00, 32'd5, 32'd0);
        drain();

        // Error cases: out-of-range word, illegal cmd store, then addr 0 unchanged.
        exp_q.push_back('{0, 32'd0, 1'b1});
        send(0, 0, 2'b10, 32'd61, 32'd0);
        drain();
        exp_q.push_back('{1, 32'd0, 1'b1});
        send(1, 1, 2'b11, 32'd0, 32'h55555555);
        drain();
        exp_q.push_back('{0, 32'hF00F81AA, 1'b0});
        send(0, 0, 2'b10, 32'd0, 32'd0);
        drain();

        // Wrap boundary and top-of-memory accesses.
        exp_q.push_back('{0, 32'd0, 1'b1});
        send(0, 1, 2'b10, 32'hFFFF_FFFE, 32'hCAFEF00D);
        drain();
        wr_q.push_back('{32'd63, 32'h0000005A, 2'b00});
        exp_q.push_back('{1, 32'd0, 1'b0});
        send(1, 1, 2'b00, 32'd63, 32'h0000005A);
        drain();
        exp_q.push_back('{0, 32'h5A000000, 1'b0});
        send(0, 0, 2'b10, 32'd60, 32'd0);
        drain();

        // Reset during the ACCESS cycle of an r0 store: nothing may come out.
        r0_valid = 1; r0_we = 1; r0_cmd = 2'b10; r0_addr = 32'd8; r0_wdata = 32'hDEADBEEF;
        begin
            bit got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (r0_ready) got = 1;
            end
            if (!got) chk("rst_store_ready_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        r0_valid = 0;
        resetn = 0;
        @(posedge clk); #1;
        resetn = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_write", {32'd0, mem[11], mem[10], mem[9], mem[8]}, 64'd0);

        // Contention right after reset: r0 first, then strict alternation every 3 cycles.
        acc_q.delete();
        exp_q.push_back('{0, 32'hF00F81AA, 1'b0});
        exp_q.push_back('{1, 32'h000000BE, 1'b0});
        exp_q.push_back('{0, 32'hF00F81AA, 1'b0});
        exp_q.push_back('{1, 32'h000000BE, 1'b0});
        r0_we = 0; r0_cmd = 2'b10; r0_addr = 32'd0;
        r1_we = 0; r1_cmd = 2'b00; r1_addr = 32'd5;
        r0_valid = 1; r1_valid = 1;
        begin
            int n = 0;
            while (acc_q.size() < 4 && n < 40) begin
                @(negedge clk); #1;
                n++;
            end
        end
        @(posedge clk); #1;
        r0_valid = 0; r1_valid = 0;
        drain();
        chk("cont_accepts", 64'(acc_q.size()), 64'd4);
        if (acc_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("cont_grant_id", 64'(acc_q[i].id), 64'(i % 2));
                if (i > 0) chk("cont_grant_gap", 64'(acc_q[i].cyc - acc_q[i-1].cyc), 64'd3);
            end
        end
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
